// File: rtl/music_pkg.sv
// music_pkg: shared types and constants for the song sequencer.
// The GAP state only exists when ARTIC_GAP_EN is defined.
package music_pkg;

    localparam int PERIOD_W_DEF = 16;
    localparam int DUR_W_DEF    = 10;

    // State encodings
    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_FETCH = 3'd1;
    localparam logic [2:0] ENC_LOAD  = 3'd2;
    localparam logic [2:0] ENC_PLAY  = 3'd3;
    localparam logic [2:0] ENC_GAP   = 3'd4;
    localparam logic [2:0] ENC_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_FETCH = ENC_FETCH,
        ST_LOAD  = ENC_LOAD,
        ST_PLAY  = ENC_PLAY,
`ifdef ARTIC_GAP_EN
        ST_GAP   = ENC_GAP,
`endif
        ST_DONE  = ENC_DONE
    } state_t;

    // Note entry layout: {END, period[PERIOD_W], duration[DUR_W]}
    localparam int DUR_LSB = 0;

    function automatic int end_bit(input int period_w, input int dur_w);
        return period_w + dur_w;
    endfunction

    function automatic int period_lsb(input int dur_w);
        return dur_w;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// ms_timer: tick prescaler plus millisecond counter. Raises a one-cycle
// expired pulse on the final tick of the target-th millisecond, then
// self-clears so a following interval can start on the next cycle.
module ms_timer #(
    parameter int TICK_W = 16,
    parameter int DUR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [TICK_W-1:0] ticks_per_milli,
    input  logic [DUR_W-1:0]  target,
    output logic              expired
);

    logic [TICK_W-1:0] tick_q;
    logic [DUR_W-1:0]  ms_q;
    logic [TICK_W-1:0] tick_last;
    logic              ms_strobe;
    logic [DUR_W:0]    ms_next;

    // Terminal tick decode (zero ticks_per_milli behaves as one) and expiry check
    always_comb begin
        tick_last = (ticks_per_milli == '0) ? '0 : ticks_per_milli - 1'b1;
        ms_strobe = !clear && (tick_q >= tick_last);
        ms_next   = {1'b0, ms_q} + 1'b1;
        expired   = ms_strobe && (ms_next >= {1'b0, target});
    end

    // Counter state; compare uses the live ticks_per_milli so changes apply next compare
    always_ff @(posedge clk) begin
        if (rst || clear || expired) begin
            tick_q <= '0;
            ms_q   <= '0;
        end else if (ms_strobe) begin
            tick_q <= '0;
            ms_q   <= ms_next[DUR_W-1:0];
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks a note ROM and drives the tone generator.
// Optional articulation gap between tones: define ARTIC_GAP_EN.
module song_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int DUR_W    = DUR_W_DEF
`ifdef ARTIC_GAP_EN
    ,
    parameter int GAP_MS   = 20
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               ticks_per_milli,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [PERIOD_W+DUR_W:0]   rom_data,
    output logic [PERIOD_W-1:0]       tone_period,
    output logic                      tone_en,
    output logic                      busy,
    output logic                      done
);

    localparam int END_BIT = end_bit(PERIOD_W, DUR_W);
    localparam int PER_LSB = period_lsb(DUR_W);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [PERIOD_W-1:0]   per_q, per_d;
    logic                  en_q, en_d;
    logic                  start_q;
    logic [DUR_W-1:0]      dur_q;

    logic                  ent_end;
    logic [PERIOD_W-1:0]   ent_per;
    logic [DUR_W-1:0]      ent_dur;

    logic                  tmr_clear;
    logic [DUR_W-1:0]      tmr_target;
    logic                  tmr_expired;

    logic                  advance;
    logic                  song_end;

    assign ent_end = rom_data[END_BIT];
    assign ent_per = rom_data[PER_LSB +: PERIOD_W];
    assign ent_dur = rom_data[DUR_LSB +: DUR_W];

    // Timer runs only while a timed state is active; counters sit at zero otherwise
    always_comb begin
`ifdef ARTIC_GAP_EN
        tmr_clear  = !(state_q == ST_PLAY || state_q == ST_GAP);
        tmr_target = (state_q == ST_GAP) ? DUR_W'(GAP_MS) : dur_q;
`else
        tmr_clear  = (state_q != ST_PLAY);
        tmr_target = dur_q;
`endif
    end

    ms_timer #(
        .TICK_W (16),
        .DUR_W  (DUR_W)
    ) u_ms_timer (
        .clk             (clk),
        .rst             (rst),
        .clear           (tmr_clear),
        .ticks_per_milli (ticks_per_milli),
        .target          (tmr_target),
        .expired         (tmr_expired)
    );

    // Next-state and output decode; stop overrides everything else
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        per_d    = per_q;
        en_d     = en_q;
        advance  = 1'b0;
        song_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                en_d = 1'b0;
                if (start_q) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (ent_end) begin
                    song_end = 1'b1;
                end else if (ent_dur == '0) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    per_d   = ent_per;
                    en_d    = (ent_per != '0);
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tmr_expired) begin
`ifdef ARTIC_GAP_EN
                    if (per_q != '0) begin
                        en_d    = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        advance = 1'b1;
                    end
`else
                    advance = 1'b1;
`endif
                end
            end
`ifdef ARTIC_GAP_EN
            ST_GAP: begin
                if (tmr_expired) begin
                    advance = 1'b1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Last ROM slot behaves like an END marker rather than wrapping to 0
        if (advance) begin
            if (addr_q == ADDR_LAST) begin
                song_end = 1'b1;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = ST_FETCH;
            end
        end

        if (song_end) begin
            if (loop_en) begin
                addr_d  = '0;
                state_d = ST_FETCH;
            end else begin
                en_d    = 1'b0;
                state_d = ST_DONE;
            end
        end

        if (stop) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            per_d   = '0;
            en_d    = 1'b0;
        end
    end

    // Control and tone output registers; start is registered at the pin boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            per_q   <= '0;
            en_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            per_q   <= per_d;
            en_q    <= en_d;
            start_q <= start;
        end
    end

    // Duration of the note being played, captured when the entry is decoded
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            dur_q <= ent_dur;
        end
    end

    assign rom_addr    = addr_q;
    assign tone_period = per_q;
    assign tone_en     = en_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule
